// File: rtl/rf_sched_pkg.sv
// Shared types and constants for the register-file write scheduler.
// The scoreboard is optional and is built only when RF_SCOREBOARD_EN is defined.
package rf_sched_pkg;

    typedef logic [3:0]  reg_idx_t;
    typedef logic [31:0] word_t;

    localparam reg_idx_t REG_PC = 4'd15;

    typedef enum {REQ_NONE, REQ_ALU, REQ_MEM} req_sel_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard for r0..r14 with combinational read-after-write hazard lookup.
// r15 is never tracked because the PC is always readable.
module rf_scoreboard
    import rf_sched_pkg::*;
(
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     set_valid_i,
    input  reg_idx_t set_rd_i,
    input  logic     clr_valid_i,
    input  reg_idx_t clr_rd_i,
    input  reg_idx_t rd_addr1_i,
    input  reg_idx_t rd_addr2_i,
    output logic     hazard1_o,
    output logic     hazard2_o
);

    logic [14:0] busy_q;
    logic [14:0] busy_d;
    logic [15:0] setMask;
    logic [15:0] clrMask;
    logic [15:0] busyExt;

    // Set is applied after clear so a same-cycle re-issue keeps the register busy.
    always_comb begin
        setMask = '0;
        clrMask = '0;
        if (set_valid_i && (set_rd_i != REG_PC)) begin
            setMask[set_rd_i] = 1'b1;
        end
        if (clr_valid_i && (clr_rd_i != REG_PC)) begin
            clrMask[clr_rd_i] = 1'b1;
        end
        busy_d = (busy_q & ~clrMask[14:0]) | setMask[14:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busyExt   = {1'b0, busy_q};
    assign hazard1_o = busyExt[rd_addr1_i];
    assign hazard2_o = busyExt[rd_addr2_i];

endmodule

// File: rtl/rf_write_scheduler.sv
// Arbitrates ALU and load writebacks onto the single register-bank write port, redirecting r15 to the PC.
// Define RF_SCOREBOARD_EN to build the busy scoreboard and hazard outputs; otherwise hazards are tied to 0.
module rf_write_scheduler
    import rf_sched_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [3:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [3:0]  mem_rd,
    input  logic [31:0] mem_data,
    input  logic        issue_valid,
    input  logic [3:0]  issue_rd,
    input  logic [3:0]  rd_addr1,
    input  logic [3:0]  rd_addr2,
    output logic        hazard1,
    output logic        hazard2,
    output logic        rf_we,
    output logic [3:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        pc_we,
    output logic [31:0] pc_wdata
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt_q;
    logic [3:0] starve_cnt_d;
    logic       forceAlu;
    logic       memAccept;
    logic       aluAccept;
    req_sel_t   sel;
    reg_idx_t   winRd;
    word_t      winData;

    logic     rf_we_q,    rf_we_d;
    reg_idx_t rf_waddr_q, rf_waddr_d;
    word_t    rf_wdata_q, rf_wdata_d;
    logic     pc_we_q,    pc_we_d;
    word_t    pc_wdata_q, pc_wdata_d;

    // MEM has priority unless the ALU has waited STARVE_LIMIT cycles in a row.
    assign forceAlu  = (starve_cnt_q == LIMIT);
    assign mem_ready = !forceAlu;
    assign alu_ready = forceAlu | !mem_valid;
    assign memAccept = mem_valid && mem_ready;
    assign aluAccept = alu_valid && alu_ready && !memAccept;

    always_comb begin
        sel     = REQ_NONE;
        winRd   = alu_rd;
        winData = alu_data;
        if (memAccept) begin
            sel     = REQ_MEM;
            winRd   = mem_rd;
            winData = mem_data;
        end else if (aluAccept) begin
            sel = REQ_ALU;
        end
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!alu_valid || aluAccept) begin
            starve_cnt_d = '0;
        end else if (!alu_ready && (starve_cnt_q != LIMIT)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    // Strobes are rebuilt every cycle; address and data hold when nothing is accepted.
    always_comb begin
        rf_we_d    = 1'b0;
        pc_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        pc_wdata_d = pc_wdata_q;
        if (sel != REQ_NONE) begin
            if (winRd == REG_PC) begin
                pc_we_d    = 1'b1;
                pc_wdata_d = winData;
            end else begin
                rf_we_d    = 1'b1;
                rf_waddr_d = winRd;
                rf_wdata_d = winData;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
            pc_we_q      <= 1'b0;
            pc_wdata_q   <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
            pc_we_q      <= pc_we_d;
            pc_wdata_q   <= pc_wdata_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign pc_we    = pc_we_q;
    assign pc_wdata = pc_wdata_q;

`ifdef RF_SCOREBOARD_EN
    rf_scoreboard u_scoreboard (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .set_valid_i (issue_valid),
        .set_rd_i    (issue_rd),
        .clr_valid_i (rf_we_q),
        .clr_rd_i    (rf_waddr_q),
        .rd_addr1_i  (rd_addr1),
        .rd_addr2_i  (rd_addr2),
        .hazard1_o   (hazard1),
        .hazard2_o   (hazard2)
    );
`else
    logic unused_sb;
    assign unused_sb = ^{issue_valid, issue_rd, rd_addr1, rd_addr2};
    assign hazard1   = 1'b0;
    assign hazard2   = 1'b0;
`endif

endmodule
